// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB RX byte assembler.
//   rx_asm_state_t : assembler FSM states
//   USB_SYNC_LSB   : SYNC field value assembled LSB-first
//   pid_ok()       : PID check nibble test (low nibble is complement of high)
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PID  = 2'd1,
        DATA = 2'd2,
        HALT = 2'd3
    } rx_asm_state_t;

    localparam logic [7:0] USB_SYNC_LSB = 8'h80;

    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[3:0] == ~pid[7:4];
    endfunction

endpackage

// File: rtl/usb_rx_byte_assembler_if.sv
// Bit-stream input and byte/status output bundle of the RX byte assembler.
//   slave  : assembler side (consumes clear/shift_enable/serial_in, drives status)
//   master : upstream/downstream side (drives bits, observes bytes and status)
interface usb_rx_byte_assembler_if #(
    parameter int unsigned HIST_BYTES = 3,
    parameter int unsigned CNT_W      = 7
);
    logic                    clear;
    logic                    shift_enable;
    logic                    serial_in;
    logic                    byte_ready;
    logic [7:0]              byte_data;
    logic [8*HIST_BYTES-1:0] history;
    logic                    sync_found;
    logic [7:0]              pid_data;
    logic                    pid_valid;
    logic                    pid_err;
    logic [CNT_W-1:0]        byte_count;
    logic                    overflow;

    modport slave (
        input  clear, shift_enable, serial_in,
        output byte_ready, byte_data, history, sync_found,
               pid_data, pid_valid, pid_err, byte_count, overflow
    );

    modport master (
        output clear, shift_enable, serial_in,
        input  byte_ready, byte_data, history, sync_found,
               pid_data, pid_valid, pid_err, byte_count, overflow
    );
endinterface

// File: rtl/flex_stp_sr.sv
// Generic serial-in/parallel-out shift register.
//   clk          : clock
//   n_rst        : synchronous active-low clear
//   shift_enable : shift serial_in in this cycle
//   serial_in    : incoming bit
//   parallel_out : register contents
module flex_stp_sr #(
    parameter int unsigned NUM_BITS  = 8,
    parameter int unsigned SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] next_c;

    // SHIFT_MSB=1: new bit enters bit 0; otherwise new bit enters the MSB
    always_comb begin
        next_c = parallel_out;
        if (shift_enable) begin
            if (SHIFT_MSB != 0) next_c = {parallel_out[NUM_BITS-2:0], serial_in};
            else                next_c = {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) parallel_out <= '0;
        else        parallel_out <= next_c;
    end

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// USB RX serial-to-parallel stage: SYNC hunt, PID capture/check, data byte
// assembly with ready strobe, byte count, history window and overflow.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of usb_rx_byte_assembler_if (bits in, bytes/status out)
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int unsigned HIST_BYTES   = 3,
    parameter int unsigned MAX_BYTES    = 64,
    parameter int unsigned SHIFT_MSB    = 0,
    parameter logic [7:0]  SYNC_PATTERN = USB_SYNC_LSB,
    parameter int unsigned CNT_W        = $clog2(MAX_BYTES + 1)
) (
    input logic                     clk,
    input logic                     rst,
    usb_rx_byte_assembler_if.slave  bus
);

    localparam int unsigned HIST_W = 8 * HIST_BYTES;

    rx_asm_state_t    state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       fill_q, fill_d;
    logic             sync_found_q, sync_found_d;
    logic [7:0]       pid_data_q, pid_data_d;
    logic             pid_valid_q, pid_valid_d;
    logic             pid_err_q, pid_err_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic [HIST_W-1:0] history_q, history_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             overflow_q, overflow_d;
    logic             byte_ready_q, byte_ready_d;
    logic [7:0]       sr_q;
    logic [7:0]       sr_next;

    // Register is wiped on reset or clear so hunting restarts from known zeros
    flex_stp_sr #(.NUM_BITS(8), .SHIFT_MSB(SHIFT_MSB)) u_sr (
        .clk          (clk),
        .n_rst        (~(rst | bus.clear)),
        .shift_enable (bus.shift_enable),
        .serial_in    (bus.serial_in),
        .parallel_out (sr_q)
    );

    // Value the register takes at this edge when a bit is shifted in
    assign sr_next = (SHIFT_MSB != 0) ? {sr_q[6:0], bus.serial_in}
                                      : {bus.serial_in, sr_q[7:1]};

    // Next-state and status update
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        fill_d       = fill_q;
        sync_found_d = sync_found_q;
        pid_data_d   = pid_data_q;
        pid_valid_d  = pid_valid_q;
        pid_err_d    = pid_err_q;
        byte_data_d  = byte_data_q;
        history_d    = history_q;
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;
        byte_ready_d = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.shift_enable) begin
                    // Only compare once 8 real bits are present, so reset zeros cannot match
                    if (fill_q != 3'd7) fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd7 && sr_next == SYNC_PATTERN) begin
                        sync_found_d = 1'b1;
                        bit_cnt_d    = 3'd0;
                        state_d      = PID;
                    end
                end
            end
            PID: begin
                if (bus.shift_enable) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        pid_data_d = sr_next;
                        if (pid_ok(sr_next)) begin
                            pid_valid_d = 1'b1;
                            state_d     = DATA;
                        end else begin
                            pid_err_d = 1'b1;
                            state_d   = HALT;
                        end
                    end
                end
            end
            DATA: begin
                if (bus.shift_enable) begin
                    if (byte_count_q == CNT_W'(MAX_BYTES)) begin
                        overflow_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_data_d  = sr_next;
                            history_d    = HIST_W'({sr_next, history_q} >> 8);
                            byte_count_d = byte_count_q + CNT_W'(1);
                            byte_ready_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
            end
        endcase
    end

    // State register; clear keeps the last byte and history visible
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 3'd0;
            fill_q       <= 3'd0;
            sync_found_q <= 1'b0;
            pid_data_q   <= 8'd0;
            pid_valid_q  <= 1'b0;
            pid_err_q    <= 1'b0;
            byte_data_q  <= 8'd0;
            history_q    <= '0;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            byte_ready_q <= 1'b0;
        end else if (bus.clear) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 3'd0;
            fill_q       <= 3'd0;
            sync_found_q <= 1'b0;
            pid_data_q   <= 8'd0;
            pid_valid_q  <= 1'b0;
            pid_err_q    <= 1'b0;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            fill_q       <= fill_d;
            sync_found_q <= sync_found_d;
            pid_data_q   <= pid_data_d;
            pid_valid_q  <= pid_valid_d;
            pid_err_q    <= pid_err_d;
            byte_data_q  <= byte_data_d;
            history_q    <= history_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.history    = history_q;
    assign bus.sync_found = sync_found_q;
    assign bus.pid_data   = pid_data_q;
    assign bus.pid_valid  = pid_valid_q;
    assign bus.pid_err    = pid_err_q;
    assign bus.byte_count = byte_count_q;
    assign bus.overflow   = overflow_q;

endmodule
